// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver, 8N1, LSB first, idle-high line. The rx pin is
// brought into the clk domain through a two-flop synchronizer. A start bit is
// confirmed at mid-bit so short glitches are rejected. Each data bit is then
// sampled one full bit period later, which keeps every sample at mid-bit.
// Received bytes land in a one-deep holding register with a valid/read
// handshake.
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing with parity_err
// reporting. Without it the frame is 8N1 and parity_err is tied to 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx         in   serial line, asynchronous to clk
//   rd_en      in   consumer acknowledge, pops the holding register
//   data       out  received byte, stable while data_valid is high
//   data_valid out  holding register full
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  sticky, a byte completed while the holding register was full
//   parity_err out  one-cycle pulse on an even-parity mismatch (feature only)
//   rx_busy    out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD - 1;
    localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
    localparam int CNT_W        = (BAUD_CNT_MAX > 0) ? $clog2(BAUD_CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX_C  = CNT_W'(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_HALF_C = CNT_W'(HALF_CNT);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA_C = ST_PARITY;

    // Even parity: data bits plus parity bit must contain an even number of ones.
    function automatic logic parity_bad(input logic [8:0] bits);
        parity_bad = ^bits;
    endfunction
`else
    localparam state_t AFTER_DATA_C = ST_STOP;
`endif

    logic             sync1_q, sync2_q;
    logic             rx_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             rx_busy_q, rx_busy_d;
    logic             accept_s;
`ifdef UART_RX_PARITY_EN
    logic             parity_err_q, parity_err_d;
    // Remembers a parity failure so the byte is dropped even if the stop bit is good.
    logic             par_bad_q, par_bad_d;
`endif

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous rx pin; resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, datapath and holding-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE_C;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = 1'b0;
        accept_s     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
        par_bad_d    = par_bad_q;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO_C;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF_C) begin
                    cnt_d = CNT_ZERO_C;
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        // Line went back high before mid-start: treat as a glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_MAX_C) begin
                    cnt_d     = CNT_ZERO_C;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = AFTER_DATA_C;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_MAX_C) begin
                    cnt_d   = CNT_ZERO_C;
                    state_d = ST_STOP;
                    if (parity_bad({rx_s, shift_q})) begin
                        parity_err_d = 1'b1;
                        par_bad_d    = 1'b1;
                    end else begin
                        par_bad_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_MAX_C) begin
                    cnt_d = CNT_ZERO_C;
                    if (rx_s) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        accept_s = ~par_bad_q;
`else
                        accept_s = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK: begin
                // Held-low line: wait for idle so only one frame_err is reported.
                cnt_d = CNT_ZERO_C;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO_C;
                state_d = ST_IDLE;
            end
        endcase

        // Holding register: a simultaneous read frees the slot for the new byte.
        if (accept_s) begin
            if (!data_valid_q) begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
            end else if (rd_en) begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
                overrun_d    = 1'b0;
            end else begin
                overrun_d    = 1'b1;
            end
        end else if (rd_en && data_valid_q) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end

        rx_busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO_C;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error pulse and per-frame discard flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
            par_bad_q    <= par_bad_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver, 8N1, LSB first, idle-high line. Pairs with the team's existing uart_tx on the same CLK_FREQ/BAUD parameters. Synchronizes the rx pin, detects start bits with glitch rejection, and samples each bit at mid-period. Delivers bytes through a one-deep holding register with a valid/read handshake, plus framing and overrun error reporting.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 115200, line rate in bit/s.
BAUD_CNT_MAX (localparam), CLK_FREQ/BAUD - 1, last count value of one bit period.
HALF_CNT (localparam), BAUD_CNT_MAX/2 (integer division), mid-bit offset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
rx  in  1  serial input; asynchronous to clk.
rd_en  in  1  consumer acknowledge; pops the holding register when data_valid=1.
data  out  8  received byte; stable while data_valid=1.
data_valid  out  1  holding register full.
frame_err  out  1  one-cycle pulse: stop bit sampled 0.
overrun  out  1  sticky: a byte completed while the holding register was full.
parity_err  out  1  one-cycle pulse; see Optional Feature; tied 0 otherwise.
rx_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: data=0, data_valid=0, frame_err=0, overrun=0, parity_err=0, rx_busy=0, state=IDLE. Both synchronizer flops reset to 1 (idle line).
- rx passes through a 2-flop synchronizer; rx_s below means the second flop's output. No other logic reads raw rx.
- Baud counter width: $clog2(BAUD_CNT_MAX+1). Reset to 0 on every state entry.
- IDLE: rx_s==0 -> START, count=0.
- START: count to HALF_CNT. At HALF_CNT, rx_s==0 -> DATA, count=0, bit_idx=0. Otherwise -> IDLE (glitch rejected, no error).
- DATA: at count==BAUD_CNT_MAX (mid-bit), shift rx_s into bit 7 of the shift register (right-shift, LSB first) and increment bit_idx. After the 8th sample -> STOP (or PARITY if enabled).
- STOP: at count==BAUD_CNT_MAX, sample rx_s.
  - 1: byte accepted, -> IDLE immediately (mid-stop), so a back-to-back start bit is caught.
  - 0: frame_err pulses for one cycle, byte discarded, -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. rx_busy stays high. A held-low line produces exactly one frame_err.
- Byte accept, data_valid==0: data<=byte, data_valid<=1 on the next edge.
- Byte accept, data_valid==1, rd_en==0: new byte dropped, old data kept, overrun<=1.
- Byte accept and rd_en in the same cycle while data_valid==1: new byte loaded, data_valid stays 1, no overrun.
- rd_en with data_valid==1 (no simultaneous accept): data_valid<=0, overrun<=0. rd_en with data_valid==0 has no effect.
- Latency: data_valid rises 2 (synchronizer) + 1 cycles after the mid-stop-bit sample point.
- rst mid-frame: all state is cleared at once; a partial byte is never delivered.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. PARITY state follows DATA. The parity bit is sampled at the same mid-bit point.
- If XOR(data bits, parity bit) != 0: parity_err pulses one cycle, byte discarded, frame continues to STOP.
- A framing error still takes precedence on the stop bit.
- Undefined: no PARITY state, parity_err driven constant 0, frame is 8N1.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD=1 (BAUD_CNT_MAX=15, HALF_CNT=7, 16 clk per bit), stimulus from uart_tx with the same parameters unless noted.
1. Send 0xA5, rd_en held 0 -> data=0xA5, data_valid=1, frame_err=0, overrun=0. Pulse rd_en -> data_valid=0.
2. 4-clk low glitch on idle rx -> returns to IDLE, data_valid stays 0, no error pulses.
3. Send 0x3C with stop bit forced 0, then line held low 40 clk -> one frame_err pulse, data_valid=0, rx_busy high until rx returns 1.
4. Send 0x11 then 0x22 back-to-back, no rd_en -> data=0x11, overrun=1. rd_en -> overrun=0, data_valid=0.
5. Send 0x55 with rd_en asserted exactly in the accept cycle of a second byte 0x66 -> data=0x66, data_valid=1, overrun=0.
6. Assert rst during DATA bit 4 of 0xFF, then send 0x0F -> only 0x0F delivered. With UART_RX_PARITY_EN and a wrong parity bit on 0x07 -> parity_err pulse, no data_valid.
